// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter sharing one rggen register-access bus between REQUESTERS hosts.
// Optional watchdog: define RGGEN_ARB_TIMEOUT_EN to complete stalled accesses with an error.
//
// state | meaning
// IDLE  | no access in flight; arbitrate among valid hosts
// BUSY  | granted host's request driven downstream until ready, abort or timeout
module rggen_bus_arbiter #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int REQUESTERS     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [REQUESTERS-1:0]               i_req_valid,
  input  logic [2*REQUESTERS-1:0]             i_req_access,
  input  logic [ADDRESS_WIDTH*REQUESTERS-1:0] i_req_address,
  input  logic [BUS_WIDTH*REQUESTERS-1:0]     i_req_write_data,
  input  logic [BUS_WIDTH/8*REQUESTERS-1:0]   i_req_strobe,
  output logic [REQUESTERS-1:0]               o_req_ready,
  output logic [2*REQUESTERS-1:0]             o_req_status,
  output logic [BUS_WIDTH*REQUESTERS-1:0]     o_req_read_data,
  output logic                                o_bus_valid,
  output logic [1:0]                          o_bus_access,
  output logic [ADDRESS_WIDTH-1:0]            o_bus_address,
  output logic [BUS_WIDTH-1:0]                o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]              o_bus_strobe,
  input  logic                                i_bus_ready,
  input  logic [1:0]                          i_bus_status,
  input  logic [BUS_WIDTH-1:0]                i_bus_read_data
);
  localparam int STROBE_WIDTH = BUS_WIDTH / 8;
  localparam int INDEX_WIDTH  = $clog2(REQUESTERS);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [REQUESTERS-1:0]   grant_q, grant_d;
  logic [INDEX_WIDTH-1:0]  pointer_q, pointer_d;

  logic                    busy;
  logic                    granted_valid;
  logic                    complete;
  logic                    timeout;
  logic                    done;
  logic                    found;
  int                      idx;
  logic [REQUESTERS-1:0]   winner;
  logic [INDEX_WIDTH-1:0]  next_pointer;

  if (REQUESTERS < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("rggen_bus_arbiter: REQUESTERS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  assign busy          = (state_q == BUSY);
  assign granted_valid = |(i_req_valid & grant_q);
  assign complete      = busy & granted_valid & i_bus_ready;

`ifdef RGGEN_ARB_TIMEOUT_EN
  localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [COUNT_WIDTH-1:0] count_q, count_d;

  // count_q holds the number of BUSY cycles already spent, so the limit cycle is count_q == TIMEOUT_CYCLES-1
  always_comb begin
    count_d = '0;
    if (busy && !i_bus_ready) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout = busy & granted_valid & ~i_bus_ready & (count_q == COUNT_LAST);
`else
  assign timeout = 1'b0;
`endif

  assign done = complete | timeout;

  // first valid host at or above the pointer, wrapping
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < REQUESTERS; i++) begin
      idx = (int'(pointer_q) + i) % REQUESTERS;
      if (!found && i_req_valid[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    next_pointer = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      if (grant_q[k]) begin
        next_pointer = INDEX_WIDTH'((k + 1) % REQUESTERS);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      pointer_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pointer_q <= pointer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    pointer_d = pointer_q;
    case (state_q)
      IDLE: begin
        if (|i_req_valid) begin
          state_d = BUSY;
          grant_d = winner;
        end
      end
      BUSY: begin
        if (done) begin
          state_d   = IDLE;
          grant_d   = '0;
          pointer_d = next_pointer;
        end else if (!granted_valid) begin
          // abort: the host withdrew, so it keeps its turn
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    o_req_ready      = '0;
    o_req_status     = '0;
    o_req_read_data  = '0;
    o_bus_valid      = 1'b0;
    o_bus_access     = '0;
    o_bus_address    = '0;
    o_bus_write_data = '0;
    o_bus_strobe     = '0;
    if (busy) begin
      o_bus_valid = granted_valid & ~timeout;
      for (int k = 0; k < REQUESTERS; k++) begin
        if (grant_q[k]) begin
          o_bus_access     = i_req_access[2*k +: 2];
          o_bus_address    = i_req_address[ADDRESS_WIDTH*k +: ADDRESS_WIDTH];
          o_bus_write_data = i_req_write_data[BUS_WIDTH*k +: BUS_WIDTH];
          o_bus_strobe     = i_req_strobe[STROBE_WIDTH*k +: STROBE_WIDTH];
          if (done) begin
            o_req_ready[k]                           = 1'b1;
            o_req_status[2*k +: 2]                   = timeout ? 2'b11 : i_bus_status;
            o_req_read_data[BUS_WIDTH*k +: BUS_WIDTH] = timeout ? '0 : i_bus_read_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Scoreboard bench for rggen_bus_arbiter: expected responses queued at stimulus, popped by a monitor.
module tb_rggen_bus_arbiter;
  localparam int AW = 8;
  localparam int BW = 32;
  localparam int NR = 2;
  localparam int SW = BW / 8;
`ifdef RGGEN_ARB_TIMEOUT_EN
  localparam int TO_CYCLES = 4;
`else
  localparam int TO_CYCLES = 255;
`endif

  logic              i_clk;
  logic              i_rst_n;
  logic [NR-1:0]     i_req_valid;
  logic [2*NR-1:0]   i_req_access;
  logic [AW*NR-1:0]  i_req_address;
  logic [BW*NR-1:0]  i_req_write_data;
  logic [SW*NR-1:0]  i_req_strobe;
  logic [NR-1:0]     o_req_ready;
  logic [2*NR-1:0]   o_req_status;
  logic [BW*NR-1:0]  o_req_read_data;
  logic              o_bus_valid;
  logic [1:0]        o_bus_access;
  logic [AW-1:0]     o_bus_address;
  logic [BW-1:0]     o_bus_write_data;
  logic [SW-1:0]     o_bus_strobe;
  logic              i_bus_ready;
  logic [1:0]        i_bus_status;
  logic [BW-1:0]     i_bus_read_data;

  rggen_bus_arbiter #(
    .ADDRESS_WIDTH (AW),
    .BUS_WIDTH     (BW),
    .REQUESTERS    (NR),
    .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_req_valid     (i_req_valid),
    .i_req_access    (i_req_access),
    .i_req_address   (i_req_address),
    .i_req_write_data(i_req_write_data),
    .i_req_strobe    (i_req_strobe),
    .o_req_ready     (o_req_ready),
    .o_req_status    (o_req_status),
    .o_req_read_data (o_req_read_data),
    .o_bus_valid     (o_bus_valid),
    .o_bus_access    (o_bus_access),
    .o_bus_address   (o_bus_address),
    .o_bus_write_data(o_bus_write_data),
    .o_bus_strobe    (o_bus_strobe),
    .i_bus_ready     (i_bus_ready),
    .i_bus_status    (i_bus_status),
    .i_bus_read_data (i_bus_read_data)
  );

  typedef struct {
    int          host;
    logic [1:0]  status;
    logic [BW-1:0] data;
  } resp_t;

  resp_t         exp_q[$];
  resp_t         mon_r;
  int            n_cmp = 0;
  int            n_err = 0;
  logic [AW-1:0] exp_addr [NR];
  logic [1:0]    exp_acc  [NR];
  logic [BW-1:0] exp_wdat [NR];
  logic [SW-1:0] exp_strb [NR];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] all_outputs();
    return 128'({o_req_ready, o_req_status, o_req_read_data, o_bus_valid,
                 o_bus_access, o_bus_address, o_bus_write_data, o_bus_strobe});
  endfunction

  // response monitor: every negedge either pops one expectation or demands silence
  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      mon_r = exp_q.pop_front();
      check_eq("resp_ready", 128'(o_req_ready), 128'(1) << mon_r.host);
      check_eq("resp_status", 128'(o_req_status), 128'(mon_r.status) << (2 * mon_r.host));
      check_eq("resp_rdata", 128'(o_req_read_data), 128'(mon_r.data) << (BW * mon_r.host));
    end else begin
      check_eq("no_ready", 128'(o_req_ready), 128'(0));
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  task automatic set_req(input int h, input logic [1:0] acc, input logic [AW-1:0] a,
                         input logic [BW-1:0] d, input logic [SW-1:0] s);
    i_req_valid[h]              = 1'b1;
    i_req_access[2*h +: 2]      = acc;
    i_req_address[AW*h +: AW]   = a;
    i_req_write_data[BW*h +: BW] = d;
    i_req_strobe[SW*h +: SW]    = s;
    exp_addr[h] = a;
    exp_acc[h]  = acc;
    exp_wdat[h] = d;
    exp_strb[h] = s;
  endtask

  task automatic check_bus(input int h);
    check_eq("bus_valid", 128'(o_bus_valid), 128'(1));
    check_eq("bus_address", 128'(o_bus_address), 128'(exp_addr[h]));
    check_eq("bus_access", 128'(o_bus_access), 128'(exp_acc[h]));
    check_eq("bus_wdata", 128'(o_bus_write_data), 128'(exp_wdat[h]));
    check_eq("bus_strobe", 128'(o_bus_strobe), 128'(exp_strb[h]));
  endtask

  // called at the start of an IDLE cycle with requests in place; host h must win
  task automatic serve(input int h, input int nbusy, input logic [1:0] st, input logic [BW-1:0] rd);
    sample();
    check_eq("arb_idle_valid", 128'(o_bus_valid), 128'(0));
    tick();
    for (int c = 1; c <= nbusy; c++) begin
      if (c == nbusy) begin
        i_bus_ready     = 1'b1;
        i_bus_status    = st;
        i_bus_read_data = rd;
        exp_q.push_back(resp_t'{h, st, rd});
      end
      sample();
      check_bus(h);
      tick();
    end
    i_bus_ready     = 1'b0;
    i_bus_status    = 2'b00;
    i_bus_read_data = '0;
    i_req_valid[h]  = 1'b0;
  endtask

  task automatic apply_reset();
    i_rst_n          = 1'b0;
    i_req_valid      = '0;
    i_req_access     = '0;
    i_req_address    = '0;
    i_req_write_data = '0;
    i_req_strobe     = '0;
    i_bus_ready      = 1'b0;
    i_bus_status     = 2'b00;
    i_bus_read_data  = '0;
    tick();
    sample();
    check_eq("rst_outputs", all_outputs(), 128'(0));
    tick();
    i_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    apply_reset();

    // single write from host0, ready on second BUSY cycle
    tick();
    set_req(0, 2'b11, 8'h10, 32'hA5A5_A5A5, 4'hF);
    serve(0, 2, 2'b00, 32'h0);
    // pointer now 1: host1 beats host0
    set_req(0, 2'b10, 8'h20, 32'h0, 4'h0);
    set_req(1, 2'b10, 8'h24, 32'h0, 4'h0);
    serve(1, 1, 2'b00, 32'h1111_0000);
    serve(0, 3, 2'b00, 32'h2222_0000);

    // rotation from reset
    apply_reset();
    tick();
    set_req(0, 2'b11, 8'h30, 32'hCAFE_0000, 4'h1);
    set_req(1, 2'b11, 8'h34, 32'hCAFE_0001, 4'h2);
    serve(0, 2, 2'b00, 32'h0);
    serve(1, 2, 2'b00, 32'h0);
    set_req(0, 2'b10, 8'h38, 32'h0, 4'h0);
    set_req(1, 2'b10, 8'h3C, 32'h0, 4'h0);
    serve(0, 1, 2'b00, 32'hAAAA_5555);
    serve(1, 2, 2'b00, 32'h5555_AAAA);

    // host1 read with error status
    set_req(1, 2'b10, 8'h04, 32'h0, 4'h0);
    serve(1, 2, 2'b10, 32'h1234_5678);

    // abort: host0 drops valid in the first BUSY cycle, ready ignored
    apply_reset();
    tick();
    set_req(0, 2'b11, 8'h40, 32'hDEAD_BEEF, 4'h3);
    sample();
    check_eq("abort_idle", 128'(o_bus_valid), 128'(0));
    tick();
    i_req_valid[0] = 1'b0;
    i_bus_ready    = 1'b1;
    sample();
    check_eq("abort_valid", 128'(o_bus_valid), 128'(0));
    tick();
    sample();
    check_eq("idle_ready_ignored", all_outputs(), 128'(0));
    tick();
    i_bus_ready = 1'b0;
    set_req(0, 2'b10, 8'h44, 32'h0, 4'h0);
    set_req(1, 2'b10, 8'h48, 32'h0, 4'h0);
    serve(0, 2, 2'b00, 32'h0000_0044);
    serve(1, 2, 2'b00, 32'h0000_0048);

    // async reset in the middle of host1's access
    set_req(0, 2'b11, 8'h4C, 32'h0BAD_F00D, 4'hC);
    serve(0, 2, 2'b00, 32'h0);
    set_req(0, 2'b10, 8'h50, 32'h0, 4'h0);
    set_req(1, 2'b10, 8'h54, 32'h0, 4'h0);
    sample();
    check_eq("pre_rst_idle", 128'(o_bus_valid), 128'(0));
    tick();
    sample();
    check_bus(1);
    tick();
    i_bus_ready = 1'b1;
    i_rst_n     = 1'b0;
    #1;
    check_eq("rst_mid_outputs", all_outputs(), 128'(0));
    sample();
    tick();
    i_bus_ready = 1'b0;
    i_rst_n     = 1'b1;
    serve(0, 2, 2'b00, 32'h0000_0050);
    serve(1, 2, 2'b00, 32'h0000_0054);

`ifdef RGGEN_ARB_TIMEOUT_EN
    // downstream never answers: error completion on the 4th BUSY cycle
    set_req(0, 2'b10, 8'h60, 32'h0, 4'h0);
    sample();
    check_eq("to_idle", 128'(o_bus_valid), 128'(0));
    tick();
    for (int c = 1; c <= TO_CYCLES; c++) begin
      if (c == TO_CYCLES) exp_q.push_back(resp_t'{0, 2'b11, 32'h0});
      sample();
      check_eq("to_bus_valid", 128'(o_bus_valid), 128'(c < TO_CYCLES));
      tick();
    end
    i_req_valid[0] = 1'b0;
    set_req(0, 2'b10, 8'h64, 32'h0, 4'h0);
    set_req(1, 2'b10, 8'h68, 32'h0, 4'h0);
    serve(1, 1, 2'b00, 32'h0000_0068);
    serve(0, 1, 2'b00, 32'h0000_0064);
`endif

    tick();
    check_eq("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rggen_bus_arbiter.md
Name: rggen_bus_arbiter

Overview:
- Shares one rggen register-access bus (the valid/access/address/write_data/strobe request plus ready/status/read_data response) between REQUESTERS independent hosts, e.g. the APB adapter and a debug/backdoor host.
- Sits between the bus adapters and the register-block common adapter.
- Round-robin grant; one access in flight; the grant is held until the downstream completes.

Parameters:
ADDRESS_WIDTH, 8, request address width
BUS_WIDTH, 32, data width; strobe is BUS_WIDTH/8
REQUESTERS, 2, number of hosts (>=2)
TIMEOUT_CYCLES, 255, watchdog limit; used only with RGGEN_ARB_TIMEOUT_EN

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_req_valid  input  REQUESTERS  per-host access request
i_req_access  input  2*REQUESTERS  per-host access type {1'b1, write}
i_req_address  input  ADDRESS_WIDTH*REQUESTERS  per-host address
i_req_write_data  input  BUS_WIDTH*REQUESTERS  per-host write data
i_req_strobe  input  BUS_WIDTH/8*REQUESTERS  per-host byte strobe
o_req_ready  output  REQUESTERS  completion pulse to granted host
o_req_status  output  2*REQUESTERS  completion status; bit1 = error
o_req_read_data  output  BUS_WIDTH*REQUESTERS  read data
o_bus_valid  output  1  downstream request valid
o_bus_access  output  2  muxed access
o_bus_address  output  ADDRESS_WIDTH  muxed address
o_bus_write_data  output  BUS_WIDTH  muxed write data
o_bus_strobe  output  BUS_WIDTH/8  muxed strobe
i_bus_ready  input  1  downstream completion
i_bus_status  input  2  downstream status
i_bus_read_data  input  BUS_WIDTH  downstream read data

Behaviour:
- Slice k of every packed port belongs to host k (LSB-first).
- States: IDLE, BUSY. Registers: r_state, r_grant (one-hot), r_pointer (round-robin start index).
- Reset values: r_state = IDLE, r_grant = 0, r_pointer = 0. All outputs are 0 in reset and in IDLE.
- IDLE:
  - If any i_req_valid is set, pick the first set bit searching upward from r_pointer, wrapping at REQUESTERS-1 -> 0.
  - Register the winner into r_grant and move to BUSY.
  - Arbitration decision to o_bus_valid latency = 1 cycle.
- BUSY:
  - o_bus_valid = i_req_valid of the granted host.
  - o_bus_access/address/write_data/strobe = granted host's fields, combinational mux.
- Completion: in BUSY, when i_bus_ready=1 and the granted host is still valid:
  - o_req_ready[g] = 1 for that cycle only.
  - o_req_status slice g = i_bus_status; o_req_read_data slice g = i_bus_read_data.
  - Non-granted slices stay 0.
  - Next cycle: state = IDLE, r_grant = 0, r_pointer = (g+1) mod REQUESTERS.
- Minimum access time is 2 cycles. At least one IDLE cycle separates consecutive accesses.
- Hosts must hold valid and all fields stable until ready.
- Granted host drops valid in BUSY (abort):
  - o_bus_valid drops in the same cycle.
  - Next cycle state = IDLE, r_pointer unchanged, no o_req_ready pulse.
- i_bus_ready while in IDLE, or while the granted valid is low, is ignored.
- Simultaneous requests: strict rotation. A host that just completed has lowest priority next arbitration.
- New requests arriving during BUSY wait; they are not queued, only sampled in IDLE.
- Asynchronous reset mid-access: return immediately to IDLE, all outputs 0, pointer 0. No response is delivered.

Optional Feature:
- Macro: RGGEN_ARB_TIMEOUT_EN.
- Defined:
  - Counter (width clog2(TIMEOUT_CYCLES+1)) clears on entry to BUSY and increments each BUSY cycle without i_bus_ready.
  - When count reaches TIMEOUT_CYCLES and i_bus_ready=0: o_req_ready[g]=1, status slice = 2'b11, read_data slice = 0, o_bus_valid forced 0 that cycle.
  - Then IDLE with pointer advanced as for a normal completion.
  - Real ready on the limit cycle wins over the timeout.
- Undefined: no counter; BUSY waits indefinitely for i_bus_ready.

Test Plan:
- Reset, then host0 write addr 0x10, data 0xA5A5A5A5, strobe 0xF; downstream ready on 2nd BUSY cycle -> o_bus_valid 1 for 2 cycles with those fields, o_req_ready[0] pulses once, status slice0 = 2'b00, pointer = 1.
- Both hosts valid in the same cycle after reset -> host0 granted first; after completion, host1 granted next; after that, host0 again (rotation).
- Host1 read addr 0x04; downstream returns read_data 0x12345678, status 2'b10 -> o_req_read_data slice1 = 0x12345678, o_req_status slice1 = 2'b10, slice0 = 0, o_req_ready = 2'b10.
- Host0 granted, drops valid on 1st BUSY cycle -> o_bus_valid 0 same cycle, no ready pulse, IDLE next cycle, pointer still 0.
- i_rst_n asserted while BUSY -> all outputs 0 immediately, state IDLE. After release, a pending host1 request is granted with pointer 0 rules.
- With RGGEN_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, downstream never ready -> o_req_ready pulses on the 4th BUSY cycle with status 2'b11 and data 0, then IDLE.
